// File: rtl/systolic_tile_scheduler_pkg.sv
// Shared types and default geometry for the systolic tile scheduler.
package systolic_tile_scheduler_pkg;

  localparam int UNIT_NUM_DEF = 16;
  localparam int ROWS_W_DEF   = 9;
  localparam int PE_LAT_DEF   = 1;
  localparam int FIFO_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_A = 3'd2,
    S_CALC   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/systolic_tile_scheduler_checker.sv
// Simulation-only invariants on the scheduler strobes and handshake readies.
module systolic_tile_scheduler_checker
  import systolic_tile_scheduler_pkg::*;
#(
  parameter int UNIT_NUM = UNIT_NUM_DEF
) (
  input logic                         clk,
  input logic                         rst,
  input state_t                       state,
  input logic                         b_ready,
  input logic                         a_ready,
  input logic [UNIT_NUM*UNIT_NUM-1:0] weight_we,
  input logic [UNIT_NUM-1:0]          fifo_wr_en
);

  weight_we_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(weight_we));
  fifo_wr_en_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(fifo_wr_en));
  b_ready_in_load_b: assert property (@(posedge clk) disable iff (rst) b_ready |-> (state == S_LOAD_B));
  a_ready_in_load_a: assert property (@(posedge clk) disable iff (rst) a_ready |-> (state == S_LOAD_A));

endmodule

// File: rtl/systolic_tile_scheduler_skew_delay_line.sv
// 1-bit shift register exposing every tap; taps[i] is din delayed i+1 cycles.
module skew_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [DEPTH-1:0] taps,
  output logic             pending
);

  localparam logic [DEPTH-1:0] LOW_MASK = {DEPTH{1'b1}} >> 1;

  // Shift din in at tap 0 each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else begin
      taps <= (taps << 1) | DEPTH'(din);
    end
  end

  // High while some bit will still be present in the line next cycle.
  assign pending = din | (|(taps & LOW_MASK));

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Sequences one weight-stationary pass: load B weights, fill A lane FIFOs,
// issue skewed FIFO reads, then wait for the last partial sums to leave the array.
module systolic_tile_scheduler
  import systolic_tile_scheduler_pkg::*;
#(
  parameter int UNIT_NUM = UNIT_NUM_DEF,
  parameter int ROWS_W   = ROWS_W_DEF,
  parameter int PE_LAT   = PE_LAT_DEF,
  parameter int FIFO_LAT = FIFO_LAT_DEF
) (
  input  logic                         s_clk,
  input  logic                         s_rst,
  input  logic                         cfg_start,
  input  logic [ROWS_W-1:0]            cfg_rows,
  output logic                         busy,
  output logic                         done,
  input  logic                         MtrxB_slice_valid,
  output logic                         MtrxB_slice_ready,
  input  logic                         MtrxA_slice_valid,
  output logic                         MtrxA_slice_ready,
  output logic [UNIT_NUM*UNIT_NUM-1:0] weight_we,
  output logic [UNIT_NUM-1:0]          fifo_wr_en,
  output logic [UNIT_NUM-1:0]          fifo_rd_en,
  output logic [UNIT_NUM-1:0]          psum_valid
);

  localparam int LW       = $clog2(UNIT_NUM);
  localparam int BW       = 2 * LW;
  localparam int NW       = UNIT_NUM * UNIT_NUM;
  localparam int PSUM_LAT = FIFO_LAT + UNIT_NUM * PE_LAT;
  localparam int PSUM_D   = UNIT_NUM - 1 + PSUM_LAT;

  state_t              state_r;
  logic [ROWS_W-1:0]   m_r;
  logic [ROWS_W-1:0]   row_r;
  logic [ROWS_W-1:0]   rd_cnt_r;
  logic [LW-1:0]       lane_r;
  logic [BW-1:0]       b_cnt_r;
  logic                base_rd_r;
  logic                busy_r;
  logic                done_r;
  logic [NW-1:0]       weight_we_r;
  logic [UNIT_NUM-1:0] fifo_wr_en_r;
  logic [UNIT_NUM-2:0] skew_taps_s;
  logic                skew_pend_s;
  logic [PSUM_D-1:0]   psum_taps_s;
  logic                psum_pend_s;
  logic                b_hs_s;
  logic                a_hs_s;

  assign MtrxB_slice_ready = (state_r == S_LOAD_B);
  assign MtrxA_slice_ready = (state_r == S_LOAD_A);
  assign b_hs_s            = MtrxB_slice_valid & MtrxB_slice_ready;
  assign a_hs_s            = MtrxA_slice_valid & MtrxA_slice_ready;

  // Pass sequencer with registered strobes, busy and done.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_r      <= S_IDLE;
      m_r          <= '0;
      row_r        <= '0;
      rd_cnt_r     <= '0;
      lane_r       <= '0;
      b_cnt_r      <= '0;
      base_rd_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      weight_we_r  <= '0;
      fifo_wr_en_r <= '0;
    end else begin
      weight_we_r  <= '0;
      fifo_wr_en_r <= '0;
      done_r       <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cfg_start) begin
            m_r     <= cfg_rows;
            b_cnt_r <= '0;
            lane_r  <= '0;
            row_r   <= '0;
            busy_r  <= 1'b1;
            if (cfg_rows == '0) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_LOAD_B;
            end
          end
        end
        S_LOAD_B: begin
          if (b_hs_s) begin
            weight_we_r[b_cnt_r] <= 1'b1;
            b_cnt_r              <= b_cnt_r + BW'(1);
            if (b_cnt_r == BW'(NW - 1)) begin
              state_r <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (a_hs_s) begin
            fifo_wr_en_r[lane_r] <= 1'b1;
            lane_r               <= lane_r + LW'(1);
            if (lane_r == LW'(UNIT_NUM - 1)) begin
              row_r <= row_r + ROWS_W'(1);
              if (row_r == m_r - ROWS_W'(1)) begin
                state_r   <= S_CALC;
                base_rd_r <= 1'b1;
                rd_cnt_r  <= '0;
              end
            end
          end
        end
        S_CALC: begin
          // Every FIFO holds exactly M words, so reads never stall.
          rd_cnt_r <= rd_cnt_r + ROWS_W'(1);
          if (rd_cnt_r == m_r - ROWS_W'(1)) begin
            base_rd_r <= 1'b0;
            state_r   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!skew_pend_s && !psum_pend_s) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          busy_r    <= 1'b0;
          base_rd_r <= 1'b0;
        end
      endcase
    end
  end

  skew_delay_line #(.DEPTH(UNIT_NUM - 1)) u_rd_skew (
    .clk     (s_clk),
    .rst     (s_rst),
    .din     (base_rd_r),
    .taps    (skew_taps_s),
    .pending (skew_pend_s)
  );

  // Row r's psum emerges PSUM_LAT cycles after its lane read, i.e. base_rd delayed r+PSUM_LAT.
  skew_delay_line #(.DEPTH(PSUM_D)) u_psum_delay (
    .clk     (s_clk),
    .rst     (s_rst),
    .din     (base_rd_r),
    .taps    (psum_taps_s),
    .pending (psum_pend_s)
  );

  assign busy       = busy_r;
  assign done       = done_r;
  assign weight_we  = weight_we_r;
  assign fifo_wr_en = fifo_wr_en_r;
  assign fifo_rd_en = {skew_taps_s, base_rd_r};
  assign psum_valid = psum_taps_s[PSUM_D-1 -: UNIT_NUM];

  systolic_tile_scheduler_checker #(.UNIT_NUM(UNIT_NUM)) u_checker (
    .clk        (s_clk),
    .rst        (s_rst),
    .state      (state_r),
    .b_ready    (MtrxB_slice_ready),
    .a_ready    (MtrxA_slice_ready),
    .weight_we  (weight_we_r),
    .fifo_wr_en (fifo_wr_en_r)
  );

endmodule
